// File: rtl/arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
//
// ArbState  : arbiter FSM state (idle, serving fetch, serving data)
// ArbGrant  : which requester was granted last (used by the alternating build)
// mem_req_t : requester fields muxed onto the single memory port
//
// mem_req_t carries ARB_WORD_W-bit address/data fields; keep ARB_WORD_W equal
// to the WORD_SIZE the arbiter is built with.
package arb_pkg;

    localparam int ARB_WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } ArbState;

    typedef enum logic {
        GRANT_INSTR,
        GRANT_DATA
    } ArbGrant;

    typedef struct packed {
        logic [ARB_WORD_W-1:0] addr;
        logic [ARB_WORD_W-1:0] wdata;
        logic                  read;
        logic                  write;
    } mem_req_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of cycles a pending fetch has lost arbitration.
//
// Ports:
//   Clock, Reset : clock and asynchronous active-high reset
//   clear        : return the count to zero (has priority over inc)
//   inc          : add one, saturating at LIMIT
//   at_limit     : count equals LIMIT
module arb_starve_counter #(
    parameter int LIMIT    = 4,
    parameter int CNT_BITS = 3
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    localparam logic [CNT_BITS-1:0] LIMIT_C = CNT_BITS'(LIMIT);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch port and the
// data port. One transaction at a time; each requester gets a waitrequest so
// the pipeline stalls on contention. Default priority is data first, with a
// starvation counter that forces a fetch grant after STARVE_LIMIT lost cycles.
//
// Build option: define ARB_ROUND_ROBIN_EN to replace fixed data priority with
// alternation on a last-grant register (no starvation counter then).
//
// Ports:
//   Clock, Reset                  : clock, asynchronous active-high reset
//   InstrReq/InstrAddr            : fetch read request and address
//   InstrRData/InstrWaitreq       : fetch read data and stall
//   DataRead/DataWrite/DataAddr   : data request strobes and address
//   DataWData                     : store data
//   DataRData/DataWaitreq         : load data and stall
//   MemAddr/MemWData              : memory address and write data
//   MemRead/MemWrite              : memory strobes
//   MemRData/MemWaitreq           : memory read data and not-ready
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_BITS     = 3
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 InstrReq,
    input  logic [WORD_SIZE-1:0] InstrAddr,
    output logic [WORD_SIZE-1:0] InstrRData,
    output logic                 InstrWaitreq,
    input  logic                 DataRead,
    input  logic                 DataWrite,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataWData,
    output logic [WORD_SIZE-1:0] DataRData,
    output logic                 DataWaitreq,
    output logic [WORD_SIZE-1:0] MemAddr,
    output logic [WORD_SIZE-1:0] MemWData,
    output logic                 MemRead,
    output logic                 MemWrite,
    input  logic [WORD_SIZE-1:0] MemRData,
    input  logic                 MemWaitreq
);

    ArbState  state_q, state_d;
    ArbState  arb_pick;
    mem_req_t req;

    logic data_req;
    logic instr_done;
    logic data_done;
    logic data_load_done;

    logic [WORD_SIZE-1:0] instr_rdata_q, instr_rdata_d;
    logic [WORD_SIZE-1:0] data_rdata_q, data_rdata_d;

    assign data_req       = DataRead | DataWrite;
    assign instr_done     = (state_q == SERVE_I) & ~MemWaitreq;
    assign data_done      = (state_q == SERVE_D) & ~MemWaitreq;
    // A combined read+write is a write, so it never returns load data.
    assign data_load_done = data_done & DataRead & ~DataWrite;

`ifdef ARB_ROUND_ROBIN_EN
    ArbGrant last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (instr_done) begin
            last_grant_d = GRANT_INSTR;
        end else if (data_done) begin
            last_grant_d = GRANT_DATA;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_grant_q <= GRANT_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Uses last_grant_d so a grant completing this cycle already counts.
    always_comb begin
        arb_pick = IDLE;
        if (InstrReq && data_req) begin
            arb_pick = (last_grant_d == GRANT_DATA) ? SERVE_I : SERVE_D;
        end else if (data_req) begin
            arb_pick = SERVE_D;
        end else if (InstrReq) begin
            arb_pick = SERVE_I;
        end
    end
`else
    logic starve_at_limit;
    logic starve_force;

    arb_starve_counter #(
        .LIMIT   (STARVE_LIMIT),
        .CNT_BITS(CNT_BITS)
    ) u_starve (
        .Clock   (Clock),
        .Reset   (Reset),
        .clear   (~InstrReq | instr_done),
        .inc     (InstrReq & (state_q != SERVE_I)),
        .at_limit(starve_at_limit)
    );

    // While fetch is being served it is not losing; the count only clears on
    // the following edge, so ignore a stale limit during SERVE_I.
    assign starve_force = starve_at_limit & InstrReq & (state_q != SERVE_I);

    always_comb begin
        arb_pick = IDLE;
        if (starve_force) begin
            arb_pick = SERVE_I;
        end else if (data_req) begin
            arb_pick = SERVE_D;
        end else if (InstrReq) begin
            arb_pick = SERVE_I;
        end
    end
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Re-arbitrate from IDLE or on a completion cycle, so grants chain with no bubble.
    always_comb begin
        state_d = state_q;
        if ((state_q == IDLE) || instr_done || data_done) begin
            state_d = arb_pick;
        end
    end

    always_comb begin
        req = '0;
        case (state_q)
            SERVE_I: begin
                req.addr = ARB_WORD_W'(InstrAddr);
                req.read = 1'b1;
            end
            SERVE_D: begin
                req.addr  = ARB_WORD_W'(DataAddr);
                req.wdata = ARB_WORD_W'(DataWData);
                req.write = DataWrite;
                req.read  = DataRead & ~DataWrite;
            end
            default: ;
        endcase
    end

    assign MemAddr  = WORD_SIZE'(req.addr);
    assign MemWData = WORD_SIZE'(req.wdata);
    assign MemRead  = req.read;
    assign MemWrite = req.write;

    assign InstrWaitreq = InstrReq & ~instr_done;
    assign DataWaitreq  = data_req & ~data_done;

    // Read data passes straight through on completion; otherwise the last
    // value returned to that requester is held.
    always_comb begin
        instr_rdata_d = instr_done     ? MemRData : instr_rdata_q;
        data_rdata_d  = data_load_done ? MemRData : data_rdata_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    assign InstrRData = instr_rdata_d;
    assign DataRData  = data_rdata_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (default build: fixed data
// priority with starvation counter, STARVE_LIMIT = 4).
module tb_mem_port_arbiter;

    localparam int W   = 16;
    localparam int LIM = 4;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         InstrReq;
    logic [W-1:0] InstrAddr;
    logic [W-1:0] InstrRData;
    logic         InstrWaitreq;
    logic         DataRead;
    logic         DataWrite;
    logic [W-1:0] DataAddr;
    logic [W-1:0] DataWData;
    logic [W-1:0] DataRData;
    logic         DataWaitreq;
    logic [W-1:0] MemAddr;
    logic [W-1:0] MemWData;
    logic         MemRead;
    logic         MemWrite;
    logic [W-1:0] MemRData;
    logic         MemWaitreq;

    logic         mem_wait;
    logic [W-1:0] mem     [0:1023];
    logic [W-1:0] ref_mem [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    mem_port_arbiter #(
        .WORD_SIZE   (W),
        .STARVE_LIMIT(LIM),
        .CNT_BITS    (3)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .InstrReq    (InstrReq),
        .InstrAddr   (InstrAddr),
        .InstrRData  (InstrRData),
        .InstrWaitreq(InstrWaitreq),
        .DataRead    (DataRead),
        .DataWrite   (DataWrite),
        .DataAddr    (DataAddr),
        .DataWData   (DataWData),
        .DataRData   (DataRData),
        .DataWaitreq (DataWaitreq),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemRData    (MemRData),
        .MemWaitreq  (MemWaitreq)
    );

    // Memory model: combinational read, write on a completed write cycle.
    assign MemWaitreq = mem_wait;
    assign MemRData   = mem[MemAddr[9:0]];
    always @(posedge Clock) begin
        if (MemWrite && !MemWaitreq) mem[MemAddr[9:0]] <= MemWData;
    end

    function automatic logic [W-1:0] pat(input int a);
        return 16'((a * 945) ^ 42435);
    endfunction

    task automatic preload;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     <= pat(i);
            ref_mem[i]  = pat(i);
        end
        mem[16]     <= 16'hBEEF;
        ref_mem[16]  = 16'hBEEF;
    endtask

    task automatic idle_inputs;
        InstrReq  = 1'b0; InstrAddr = '0;
        DataRead  = 1'b0; DataWrite = 1'b0;
        DataAddr  = '0;   DataWData = '0;
        mem_wait  = 1'b0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        Reset = 1'b1;
        #3;
        checks++;
        if ({MemRead, MemWrite, MemAddr, MemWData} !== '0) begin
            errors++;
            $display("FAIL reset_mem got rd=%b wr=%b a=%h wd=%h expected all 0", MemRead, MemWrite, MemAddr, MemWData);
        end
        checks++;
        if ({InstrRData, DataRData} !== '0) begin
            errors++;
            $display("FAIL reset_rdata got i=%h d=%h expected 0 0", InstrRData, DataRData);
        end
        InstrReq = 1'b1;
        #1;
        checks++;
        if (InstrWaitreq !== 1'b1) begin
            errors++;
            $display("FAIL reset_iwait got %b expected 1", InstrWaitreq);
        end
        apply_reset();
    endtask

    task automatic test_fetch_only;
        apply_reset();
        InstrReq = 1'b1; InstrAddr = 16'h0010;
        @(negedge Clock);
        checks++;
        if ({InstrWaitreq, MemRead} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_c1 got iwait=%b rd=%b expected 1 0", InstrWaitreq, MemRead);
        end
        @(negedge Clock);
        checks++;
        if ({MemRead, MemAddr, InstrRData, InstrWaitreq} !== {1'b1, 16'h0010, 16'hBEEF, 1'b0}) begin
            errors++;
            $display("FAIL fetch_c2 got rd=%b a=%h rdata=%h iwait=%b expected 1 0010 beef 0", MemRead, MemAddr, InstrRData, InstrWaitreq);
        end
        @(posedge Clock); #1 InstrReq = 1'b0;
        @(negedge Clock);
        checks++;
        if ({InstrWaitreq, InstrRData} !== {1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL fetch_after got iwait=%b rdata=%h expected 0 beef", InstrWaitreq, InstrRData);
        end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        InstrReq = 1'b1; InstrAddr = 16'h0010;
        DataRead = 1'b1; DataAddr  = 16'h0100;
        @(negedge Clock);
        checks++;
        if ({InstrWaitreq, DataWaitreq, MemRead} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_idle got iw=%b dw=%b rd=%b expected 1 1 0", InstrWaitreq, DataWaitreq, MemRead);
        end
        @(negedge Clock);
        checks++;
        if ({MemRead, MemAddr, DataWaitreq, InstrWaitreq, DataRData} !== {1'b1, 16'h0100, 1'b0, 1'b1, pat(16'h0100)}) begin
            errors++;
            $display("FAIL b2b_data got rd=%b a=%h dw=%b iw=%b rdata=%h expected 1 0100 0 1 %h", MemRead, MemAddr, DataWaitreq, InstrWaitreq, DataRData, pat(16'h0100));
        end
        @(posedge Clock); #1 DataRead = 1'b0;
        @(negedge Clock);
        checks++;
        if ({MemRead, MemWrite, InstrWaitreq} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_regrant got rd=%b wr=%b iw=%b expected 0 0 1", MemRead, MemWrite, InstrWaitreq);
        end
        @(negedge Clock);
        checks++;
        if ({MemRead, MemAddr, InstrWaitreq, InstrRData} !== {1'b1, 16'h0010, 1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL b2b_fetch got rd=%b a=%h iw=%b rdata=%h expected 1 0010 0 beef", MemRead, MemAddr, InstrWaitreq, InstrRData);
        end
        checks++;
        if (DataRData !== pat(16'h0100)) begin
            errors++;
            $display("FAIL b2b_dhold got %h expected %h", DataRData, pat(16'h0100));
        end
    endtask

    task automatic test_starvation;
        int exp_g [12];
        logic [W-1:0] ea;
        // 0 = idle, 1 = fetch, 2 = data; fetch loses 4 times from reset,
        // then 5 times after its grant (the losing count restarts from 0).
        exp_g = '{0, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 1};
        apply_reset();
        InstrReq = 1'b1; InstrAddr = 16'h0010;
        DataRead = 1'b1; DataAddr  = 16'h0100;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clock);
            ea = (exp_g[k] == 1) ? 16'h0010 : (exp_g[k] == 2) ? 16'h0100 : 16'h0000;
            checks++;
            if ({MemRead, MemAddr} !== {exp_g[k] != 0, ea}) begin
                errors++;
                $display("FAIL starve_cycle%0d got rd=%b a=%h expected %b %h", k, MemRead, MemAddr, exp_g[k] != 0, ea);
            end
        end
    endtask

    task automatic test_write_wait;
        apply_reset();
        DataWrite = 1'b1; DataAddr = 16'h0200; DataWData = 16'h1234;
        InstrReq  = 1'b1; InstrAddr = 16'h0010;
        mem_wait  = 1'b1;
        @(negedge Clock);
        checks++;
        if ({MemWrite, DataWaitreq, InstrWaitreq} !== 3'b011) begin
            errors++;
            $display("FAIL wr_idle got wr=%b dw=%b iw=%b expected 0 1 1", MemWrite, DataWaitreq, InstrWaitreq);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clock);
            checks++;
            if ({MemWrite, MemRead, MemWData, MemAddr, DataWaitreq, InstrWaitreq} !== {2'b10, 16'h1234, 16'h0200, 2'b11}) begin
                errors++;
                $display("FAIL wr_wait%0d got wr=%b rd=%b wd=%h a=%h dw=%b iw=%b expected 1 0 1234 0200 1 1", k, MemWrite, MemRead, MemWData, MemAddr, DataWaitreq, InstrWaitreq);
            end
        end
        @(posedge Clock); #1 mem_wait = 1'b0;
        @(negedge Clock);
        checks++;
        if ({MemWrite, DataWaitreq, InstrWaitreq, DataRData} !== {3'b101, 16'h0000}) begin
            errors++;
            $display("FAIL wr_done got wr=%b dw=%b iw=%b rdata=%h expected 1 0 1 0000", MemWrite, DataWaitreq, InstrWaitreq, DataRData);
        end
        @(posedge Clock); #1 DataWrite = 1'b0; InstrReq = 1'b0;
        repeat (2) @(negedge Clock);
        checks++;
        if (mem[10'h200] !== 16'h1234) begin
            errors++;
            $display("FAIL wr_mem got %h expected 1234", mem[10'h200]);
        end
    endtask

    task automatic test_read_write_both;
        apply_reset();
        DataRead = 1'b1; DataWrite = 1'b1; DataAddr = 16'h0300; DataWData = 16'h5A5A;
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if ({MemWrite, MemRead, DataWaitreq, DataRData, MemWData} !== {3'b100, 16'h0000, 16'h5A5A}) begin
            errors++;
            $display("FAIL rw_both got wr=%b rd=%b dw=%b rdata=%h wd=%h expected 1 0 0 0000 5a5a", MemWrite, MemRead, DataWaitreq, DataRData, MemWData);
        end
        @(posedge Clock); #1 DataRead = 1'b0; DataWrite = 1'b0;
    endtask

    task automatic test_reset_mid;
        apply_reset();
        DataRead = 1'b1; DataAddr = 16'h0040; mem_wait = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if ({MemRead, DataWaitreq} !== 2'b11) begin
            errors++;
            $display("FAIL mid_serve got rd=%b dw=%b expected 1 1", MemRead, DataWaitreq);
        end
        #1 Reset = 1'b1;
        #1;
        checks++;
        if ({MemRead, MemWrite, MemAddr} !== '0) begin
            errors++;
            $display("FAIL mid_reset got rd=%b wr=%b a=%h expected 0 0 0000", MemRead, MemWrite, MemAddr);
        end
        #1 Reset = 1'b0;
        @(posedge Clock); #1 mem_wait = 1'b0;
        @(negedge Clock);
        checks++;
        if ({MemRead, DataWaitreq, DataRData} !== {2'b10, pat(16'h0040)}) begin
            errors++;
            $display("FAIL mid_retry got rd=%b dw=%b rdata=%h expected 1 0 %h", MemRead, DataWaitreq, DataRData, pat(16'h0040));
        end
        @(posedge Clock); #1 DataRead = 1'b0;
    endtask

    // Randomized traffic against a cycle-level model of the grant rules.
    task automatic test_random;
        int srv, srv_n, lost, lost_n, r;
        logic ireq, dreq, done, e_iw, e_dw, e_rd, e_wr, i_fin, d_fin;
        logic [W-1:0] e_addr, e_ird, e_drd;
        apply_reset();
        preload();
        srv = 0; lost = 0; e_ird = '0; e_drd = '0;
        for (int n = 0; n < 600; n++) begin
            @(negedge Clock);
            ireq   = InstrReq;
            dreq   = DataRead | DataWrite;
            done   = (srv != 0) && !mem_wait;
            e_rd   = (srv == 1) || (srv == 2 && DataRead && !DataWrite);
            e_wr   = (srv == 2) && DataWrite;
            e_addr = (srv == 1) ? InstrAddr : (srv == 2) ? DataAddr : '0;
            e_iw   = ireq && !(srv == 1 && done);
            e_dw   = dreq && !(srv == 2 && done);
            if (srv == 1 && done) e_ird = ref_mem[InstrAddr[9:0]];
            if (srv == 2 && done && DataRead && !DataWrite) e_drd = ref_mem[DataAddr[9:0]];
            checks++;
            if ({MemRead, MemWrite, MemAddr, InstrWaitreq, DataWaitreq} !== {e_rd, e_wr, e_addr, e_iw, e_dw}) begin
                errors++;
                $display("FAIL rand_ctl%0d got rd=%b wr=%b a=%h iw=%b dw=%b expected %b %b %h %b %b", n, MemRead, MemWrite, MemAddr, InstrWaitreq, DataWaitreq, e_rd, e_wr, e_addr, e_iw, e_dw);
            end
            checks++;
            if ({InstrRData, DataRData} !== {e_ird, e_drd}) begin
                errors++;
                $display("FAIL rand_rdata%0d got i=%h d=%h expected %h %h", n, InstrRData, DataRData, e_ird, e_drd);
            end
            if (e_wr) begin
                checks++;
                if (MemWData !== DataWData) begin
                    errors++;
                    $display("FAIL rand_wdata%0d got %h expected %h", n, MemWData, DataWData);
                end
            end
            if (srv == 2 && done && DataWrite) ref_mem[DataAddr[9:0]] = DataWData;
            if (srv == 0 || done) begin
                if (lost == LIM && ireq && srv != 1) srv_n = 1;
                else if (dreq)                       srv_n = 2;
                else if (ireq)                       srv_n = 1;
                else                                 srv_n = 0;
            end else begin
                srv_n = srv;
            end
            if (!ireq)         lost_n = 0;
            else if (srv == 1) lost_n = done ? 0 : lost;
            else               lost_n = (lost < LIM) ? lost + 1 : LIM;
            i_fin = ireq && !e_iw;
            d_fin = dreq && !e_dw;
            @(posedge Clock); #1;
            srv  = srv_n;
            lost = lost_n;
            if (!InstrReq || i_fin) begin
                InstrReq  = ($urandom_range(0, 3) != 0);
                InstrAddr = 16'($urandom_range(0, 1023));
            end
            if (!(DataRead || DataWrite) || d_fin) begin
                r         = int'($urandom_range(0, 7));
                DataRead  = (r >= 3 && r <= 5) || (r == 7);
                DataWrite = (r >= 6);
                DataAddr  = 16'($urandom_range(0, 1023));
                DataWData = 16'($urandom);
            end
            mem_wait = ($urandom_range(0, 2) == 0);
        end
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;
        preload();
        test_reset();
        test_fetch_only();
        test_back_to_back();
        test_starvation();
        test_write_wait();
        test_read_write_both();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
